// File: rtl/div_unit_if.sv
// div_unit_if: handshake/data bundle between the EX stage and the divider.
//   signed_div_i : 1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held high by EX until ready_o is seen
//   annul_i      : abort the current operation (flush/exception)
//   result_o     : {remainder, quotient}
//   ready_o      : result valid
//   busy_o       : divider is not idle
// Modports: master = EX stage side, slave = divider side.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, one quotient bit per
// clock, MSB first. Result is {remainder, quotient} for HI/LO.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : div_unit_if.slave (operands, start/annul in; result/ready/busy out)
// Parameters:
//   WIDTH : operand width (>= 2)
//   CNT_W : iteration counter width
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     op1_mag, op2_mag;
  logic [WIDTH:0]       partial, trial;
  logic [WIDTH-1:0]     rem_next, quot_next;
  logic                 q_bit;

  // Operand magnitudes used at capture; signed negatives become positive.
  always_comb begin
    op1_mag = bus.opdata1_i;
    op2_mag = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) op1_mag = -bus.opdata1_i;
    if (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) op2_mag = -bus.opdata2_i;
  end

  // One restoring step. quot_q starts as the dividend and is shifted left,
  // so its MSB is the next dividend bit and its LSB collects quotient bits.
  // The top bit of the WIDTH+1 bit difference is the borrow.
  always_comb begin
    partial = {rem_q, quot_q[WIDTH-1]};
    trial   = partial - {1'b0, dvs_q};
    q_bit   = ~trial[WIDTH];
    if (q_bit) rem_next = trial[WIDTH-1:0];
    else       rem_next = partial[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], q_bit};
  end

  // Next-state and registered-output logic. annul_i wins over every
  // completion path; dropping start_i in END returns to IDLE the same way.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          quot_d     = op1_mag;
          dvs_d      = op2_mag;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quot_d = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
          neg_rem_d  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
          busy_d     = 1'b1;
          if (bus.opdata2_i == '0) state_d = S_BYZERO;
          else                     state_d = S_ON;
        end
      end

      S_BYZERO: begin
        if (bus.annul_i) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b0;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end

      S_ON: begin
        if (bus.annul_i) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b0;
        end else begin
          rem_d  = rem_next;
          quot_d = quot_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            // Sign correction happens here so END only has to hold the value.
            state_d = S_END;
            ready_d = 1'b1;
            result_d[2*WIDTH-1:WIDTH] = neg_rem_q  ? -rem_next  : rem_next;
            result_d[WIDTH-1:0]       = neg_quot_q ? -quot_next : quot_next;
          end
        end
      end

      S_END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        result_d = '0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit with a 32-bit and an 8-bit
// instance. A cycle-level behavioural model (plain integer division plus a
// latency countdown) predicts ready/busy/result and is compared every cycle;
// hand-computed literals pin the key cases.
module tb_div_unit;

  logic clk;
  logic rst;
  bit   checking;
  int   vectors;
  int   miscompares;

  div_unit_if #(.WIDTH(32)) bus32 ();
  div_unit_if #(.WIDTH(8))  bus8 ();

  div_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  div_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, index 0 = 32-bit instance, 1 = 8-bit instance.
  bit          m_busy  [2];
  bit          m_ready [2];
  int          m_lat   [2];
  logic [63:0] m_res   [2];
  logic [63:0] m_pend  [2];

  // {remainder, quotient} from plain arithmetic; MIPS semantics, div-by-zero = 0.
  function automatic logic [63:0] expectedResult(input bit sgn, input logic [31:0] a,
                                                 input logic [31:0] b, input int w);
    longint mask, sa, sb, q, r;
    mask = (longint'(1) << w) - 1;
    sa = longint'({32'b0, a}) & mask;
    sb = longint'({32'b0, b}) & mask;
    if (sb == 0) return 64'b0;
    if (sgn && ((sa >> (w-1)) & 1) == 1) sa = sa - (longint'(1) << w);
    if (sgn && ((sb >> (w-1)) & 1) == 1) sb = sb - (longint'(1) << w);
    q = sa / sb;
    r = sa % sb;
    return 64'((r & mask) << w) | 64'(q & mask);
  endfunction

  task automatic modelStep(input int i, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit st, input bit an, input int w);
    if (rst) begin
      m_busy[i] = 0; m_ready[i] = 0; m_lat[i] = 0; m_res[i] = '0;
    end else if (!m_busy[i]) begin
      m_ready[i] = 0;
      m_res[i]   = '0;
      if (st && !an) begin
        m_busy[i] = 1;
        m_lat[i]  = ((b & ((64'd1 << w) - 1)) == 0) ? 1 : w;
        m_pend[i] = expectedResult(sgn, a, b, w);
      end
    end else if (an) begin
      m_busy[i] = 0; m_ready[i] = 0; m_res[i] = '0;
    end else if (m_ready[i]) begin
      if (!st) begin
        m_busy[i] = 0; m_ready[i] = 0; m_res[i] = '0;
      end
    end else begin
      m_lat[i] = m_lat[i] - 1;
      if (m_lat[i] == 0) begin
        m_ready[i] = 1;
        m_res[i]   = m_pend[i];
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(0, bus32.signed_div_i, bus32.opdata1_i, bus32.opdata2_i,
              bus32.start_i, bus32.annul_i, 32);
    modelStep(1, bus8.signed_div_i, {24'b0, bus8.opdata1_i}, {24'b0, bus8.opdata2_i},
              bus8.start_i, bus8.annul_i, 8);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("ready32", {63'b0, bus32.ready_o}, {63'b0, m_ready[0]});
      checkOutput("busy32",  {63'b0, bus32.busy_o},  {63'b0, m_busy[0]});
      if (m_ready[0] || !m_busy[0])
        checkOutput("result32", bus32.result_o, m_ready[0] ? m_res[0] : 64'b0);
      checkOutput("ready8", {63'b0, bus8.ready_o}, {63'b0, m_ready[1]});
      checkOutput("busy8",  {63'b0, bus8.busy_o},  {63'b0, m_busy[1]});
      if (m_ready[1] || !m_busy[1])
        checkOutput("result8", {48'b0, bus8.result_o}, m_ready[1] ? m_res[1] : 64'b0);
    end
  end

  task automatic applyStimulus(input int inst, input bit sgn, input logic [31:0] a,
                               input logic [31:0] b, input bit st, input bit an);
    if (inst == 0) begin
      bus32.signed_div_i = sgn;
      bus32.opdata1_i    = a;
      bus32.opdata2_i    = b;
      bus32.start_i      = st;
      bus32.annul_i      = an;
    end else begin
      bus8.signed_div_i = sgn;
      bus8.opdata1_i    = a[7:0];
      bus8.opdata2_i    = b[7:0];
      bus8.start_i      = st;
      bus8.annul_i      = an;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit         sgn;
    logic [7:0] a;
    logic [7:0] b;
  } vec8_t;

  vec8_t table8 [5];

  initial begin
    vectors     = 0;
    miscompares = 0;
    checking    = 0;
    rst         = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step(1);
    checking = 1;
    step(1);
    checkOutput("reset_result32", bus32.result_o, 64'b0);
    checkOutput("reset_ready32", {63'b0, bus32.ready_o}, 64'b0);
    checkOutput("reset_busy32", {63'b0, bus32.busy_o}, 64'b0);
    rst = 1'b0;
    step(1);

    // Unsigned 100 / 7 with operands changed while the result is held.
    $display("[TB] unsigned 100/7");
    applyStimulus(0, 0, 32'd100, 32'd7, 1, 0);
    step(1);
    checkOutput("t1_busy_edge1", {63'b0, bus32.busy_o}, 64'd1);
    step(31);
    checkOutput("t1_ready_edge32", {63'b0, bus32.ready_o}, 64'd0);
    step(1);
    checkOutput("t1_ready_edge33", {63'b0, bus32.ready_o}, 64'd1);
    checkOutput("t1_result", bus32.result_o, 64'h00000002_0000000E);
    applyStimulus(0, 1, 32'd55, 32'd3, 1, 0);
    step(2);
    checkOutput("t1_result_held", bus32.result_o, 64'h00000002_0000000E);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(1);
    checkOutput("t1_ready_drop", {63'b0, bus32.ready_o}, 64'd0);
    checkOutput("t1_busy_drop", {63'b0, bus32.busy_o}, 64'd0);

    // Signed cases: remainder sign follows the dividend.
    $display("[TB] signed -7/2 and 7/-2");
    applyStimulus(0, 1, 32'hFFFF_FFF9, 32'd2, 1, 0);
    step(33);
    checkOutput("t2_neg7_div2", bus32.result_o, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(1);
    applyStimulus(0, 1, 32'd7, 32'hFFFF_FFFE, 1, 0);
    step(33);
    checkOutput("t2_7_divneg2", bus32.result_o, 64'h00000001_FFFFFFFD);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(1);

    // Zero divisor, signed then unsigned.
    $display("[TB] divide by zero");
    applyStimulus(0, 1, 32'hFFFF_FFFB, 32'd0, 1, 0);
    step(1);
    checkOutput("t3_ready_edge1", {63'b0, bus32.ready_o}, 64'd0);
    step(1);
    checkOutput("t3_ready_edge2", {63'b0, bus32.ready_o}, 64'd1);
    checkOutput("t3_result", bus32.result_o, 64'b0);
    applyStimulus(0, 1, 32'd9, 32'd4, 1, 0);
    step(2);
    checkOutput("t3_result_held", bus32.result_o, 64'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 32'd9, 32'd0, 1, 0);
    step(2);
    checkOutput("t3_unsigned_ready", {63'b0, bus32.ready_o}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(1);

    // Annul mid-operation, restart, then annul on the completing edge.
    $display("[TB] annul");
    applyStimulus(0, 0, 32'd100, 32'd7, 1, 0);
    step(9);
    applyStimulus(0, 0, 32'd100, 32'd7, 0, 1);
    step(1);
    checkOutput("t4_busy_after_annul", {63'b0, bus32.busy_o}, 64'd0);
    applyStimulus(0, 0, 32'd1000, 32'd10, 1, 0);
    step(32);
    checkOutput("t4_restart_not_ready", {63'b0, bus32.ready_o}, 64'd0);
    step(1);
    checkOutput("t4_restart_result", bus32.result_o, 64'h00000000_00000064);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 32'd100, 32'd7, 1, 0);
    step(32);
    applyStimulus(0, 0, 32'd100, 32'd7, 1, 1);
    step(1);
    checkOutput("t4_annul_completion", {63'b0, bus32.ready_o}, 64'd0);
    step(1);
    checkOutput("t4_start_with_annul", {63'b0, bus32.busy_o}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(2);

    // 8-bit instance: overflow wrap and all-ones / 1.
    $display("[TB] width 8");
    applyStimulus(1, 1, 32'h80, 32'hFF, 1, 0);
    step(8);
    checkOutput("t5_not_ready_edge8", {63'b0, bus8.ready_o}, 64'd0);
    step(1);
    checkOutput("t5_overflow", {48'b0, bus8.result_o}, 64'h0080);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step(1);
    applyStimulus(1, 0, 32'hFF, 32'h01, 1, 0);
    step(9);
    checkOutput("t5_allones", {48'b0, bus8.result_o}, 64'h00FF);
    applyStimulus(1, 0, 0, 0, 0, 0);
    step(1);

    table8[0] = '{1, 8'hF9, 8'h02};
    table8[1] = '{0, 8'd200, 8'd3};
    table8[2] = '{1, 8'h07, 8'hFE};
    table8[3] = '{1, 8'h85, 8'h07};
    table8[4] = '{0, 8'h7F, 8'hFF};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, table8[k].sgn, {24'b0, table8[k].a}, {24'b0, table8[k].b}, 1, 0);
      step(10);
      applyStimulus(1, 0, 0, 0, 0, 0);
      step(1);
    end

    // Reset during ON and during END.
    $display("[TB] reset mid-operation");
    applyStimulus(0, 0, 32'd50, 32'd5, 1, 0);
    step(5);
    rst = 1'b1;
    step(1);
    checkOutput("t6_busy_rst_on", {63'b0, bus32.busy_o}, 64'd0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 32'd50, 32'd5, 1, 0);
    step(33);
    checkOutput("t6_result_after_rst", bus32.result_o, 64'h00000000_0000000A);
    rst = 1'b1;
    step(1);
    checkOutput("t6_ready_rst_end", {63'b0, bus32.ready_o}, 64'd0);
    checkOutput("t6_result_rst_end", bus32.result_o, 64'b0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step(2);

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
